bc_controller_v2: RTL and testbench

- Parametrised second-generation hardwired control unit for the basic computer datapath.
- Sequences fetch/decode/execute with an internal sequence counter; drives bus-select, a flat control-strobe vector and an ALU opcode to the datapath.
- Adds the full memory-reference set (BUN, BSA, ISZ), the I/O instruction group, the interrupt cycle (IEN/R) and a synchronous halt/restart.

---
 rtl/bc_controller_v2.sv | 142 ++++++++++++++
 tb/tb_bc_controller_v2.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/bc_controller_v2.sv
// bc_controller_v2: hardwired fetch/decode/execute control unit with I/O, interrupt cycle and halt
module bc_controller_v2 #(
  parameter int WIDTH      = 16,
  parameter int ADDR_W     = 12,
  parameter int CTRL_LNGTH = 20,
  parameter int INT_EN     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      IR,
  input  logic                  Z,
  input  logic                  N,
  input  logic                  E_IN,
  input  logic                  DR_Z,
  input  logic                  FGI,
  input  logic                  FGO,
  input  logic                  START,
  output logic [2:0]            BUS_SEL,
  output logic [2:0]            ALU_OP,
  output logic [CTRL_LNGTH-1:0] CTRL,
  output logic                  HALTED,
  output logic [2:0]            T_CNT
);
  localparam logic [2:0] T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3, T4 = 3'd4, T5 = 3'd5, T6 = 3'd6;
  localparam logic [2:0] B_AR = 3'd1, B_PC = 3'd2, B_DR = 3'd3, B_AC = 3'd4, B_IR = 3'd5, B_TR = 3'd6, B_MEM = 3'd7;
  localparam logic [2:0] A_ADD = 3'd0, A_AND = 3'd1, A_DR = 3'd2, A_COM = 3'd3, A_SHR = 3'd4, A_SHL = 3'd5, A_INPR = 3'd6;
  localparam int LD_AR = 0, INR_AR = 1, CLR_AR = 2, LD_PC = 3, INR_PC = 4, CLR_PC = 5, LD_DR = 6, INR_DR = 7;
  localparam int LD_AC = 8, INR_AC = 9, CLR_AC = 10, LD_IR = 11, LD_TR = 12, MEM_WR = 13, CMP_E = 14, CLR_E = 15;
  localparam int LD_E = 16, LD_OUTR = 17, CLR_FGI = 18, CLR_FGO = 19;
  logic [2:0] r_sc;
  logic       r_s, r_r, r_ien, r_i;
  logic [7:0] r_d;
  logic [2:0] w_bus, w_alu;
  logic [CTRL_LNGTH-1:0] w_ctrl;
  logic       w_clr, w_hlt, w_ion, w_iof;
  // decode the current timing step into strobes, SC clear and flag side effects
  always_comb begin
    w_bus  = '0;
    w_alu  = A_ADD;
    w_ctrl = '0;
    w_clr  = 1'b0;
    w_hlt  = 1'b0;
    w_ion  = 1'b0;
    w_iof  = 1'b0;
    if (r_s) begin
      if (r_sc == 3'd7 || (r_sc > T3 && r_d == '0)) w_clr = 1'b1;
      else if (r_r && r_sc < T3) begin
        case (r_sc)
          T0: begin w_ctrl[CLR_AR] = 1'b1; w_bus = B_PC; w_ctrl[LD_TR] = 1'b1; end
          T1: begin w_bus = B_TR; w_ctrl[MEM_WR] = 1'b1; w_ctrl[CLR_PC] = 1'b1; end
          default: begin w_ctrl[INR_PC] = 1'b1; w_clr = 1'b1; end
        endcase
      end else begin
        case (r_sc)
          T0: begin w_bus = B_PC; w_ctrl[LD_AR] = 1'b1; end
          T1: begin w_bus = B_MEM; w_ctrl[LD_IR] = 1'b1; w_ctrl[INR_PC] = 1'b1; end
          T2: begin w_bus = B_IR; w_ctrl[LD_AR] = 1'b1; end
          T3: begin
            if (r_d[7] && !r_i) begin
              w_clr = 1'b1;
              if (IR[11]) w_ctrl[CLR_AC] = 1'b1;
              else if (IR[10]) w_ctrl[CLR_E] = 1'b1;
              else if (IR[9]) begin w_ctrl[LD_AC] = 1'b1; w_alu = A_COM; end
              else if (IR[8]) w_ctrl[CMP_E] = 1'b1;
              else if (IR[7]) begin w_ctrl[LD_AC] = 1'b1; w_ctrl[LD_E] = 1'b1; w_alu = A_SHR; end
              else if (IR[6]) begin w_ctrl[LD_AC] = 1'b1; w_ctrl[LD_E] = 1'b1; w_alu = A_SHL; end
              else if (IR[5]) w_ctrl[INR_AC] = 1'b1;
              else if (IR[4]) w_ctrl[INR_PC] = !N;
              else if (IR[3]) w_ctrl[INR_PC] = N;
              else if (IR[2]) w_ctrl[INR_PC] = Z;
              else if (IR[1]) w_ctrl[INR_PC] = !E_IN;
              else if (IR[0]) w_hlt = 1'b1;
            end else if (r_d[7]) begin
              w_clr = 1'b1;
              if (IR[11]) begin w_ctrl[LD_AC] = 1'b1; w_alu = A_INPR; w_ctrl[CLR_FGI] = 1'b1; end
              else if (IR[10]) begin w_bus = B_AC; w_ctrl[LD_OUTR] = 1'b1; w_ctrl[CLR_FGO] = 1'b1; end
              else if (IR[9]) w_ctrl[INR_PC] = FGI;
              else if (IR[8]) w_ctrl[INR_PC] = FGO;
              else if (IR[7]) w_ion = 1'b1;
              else if (IR[6]) w_iof = 1'b1;
            end else if (r_i) begin
              w_bus = B_MEM;
              w_ctrl[LD_AR] = 1'b1;
            end
          end
          T4: begin
            if (r_d[0] || r_d[1] || r_d[2] || r_d[6]) begin w_bus = B_MEM; w_ctrl[LD_DR] = 1'b1; end
            else if (r_d[3]) begin w_bus = B_AC; w_ctrl[MEM_WR] = 1'b1; w_clr = 1'b1; end
            else if (r_d[4]) begin w_bus = B_AR; w_ctrl[LD_PC] = 1'b1; w_clr = 1'b1; end
            else if (r_d[5]) begin w_bus = B_PC; w_ctrl[MEM_WR] = 1'b1; w_ctrl[INR_AR] = 1'b1; end
          end
          T5: begin
            if (r_d[0]) begin w_ctrl[LD_AC] = 1'b1; w_alu = A_AND; w_clr = 1'b1; end
            else if (r_d[1]) begin w_ctrl[LD_AC] = 1'b1; w_ctrl[LD_E] = 1'b1; w_alu = A_ADD; w_clr = 1'b1; end
            else if (r_d[2]) begin w_ctrl[LD_AC] = 1'b1; w_alu = A_DR; w_clr = 1'b1; end
            else if (r_d[5]) begin w_bus = B_AR; w_ctrl[LD_PC] = 1'b1; w_clr = 1'b1; end
            else if (r_d[6]) w_ctrl[INR_DR] = 1'b1;
          end
          T6: begin
            if (r_d[6]) begin w_bus = B_DR; w_ctrl[MEM_WR] = 1'b1; w_ctrl[INR_PC] = DR_Z; end
            w_clr = 1'b1;
          end
          default: w_clr = 1'b1;
        endcase
      end
    end
  end
  // sequence counter, run/halt, interrupt and decoded-opcode registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sc  <= T0;
      r_s   <= 1'b1;
      r_r   <= 1'b0;
      r_ien <= 1'b0;
      r_i   <= 1'b0;
      r_d   <= '0;
    end else if (!r_s) begin
      r_sc <= T0;
      r_s  <= START;
    end else begin
      r_sc <= w_clr ? T0 : r_sc + 3'd1;
      if (w_hlt) r_s <= 1'b0;
      if (r_sc == T2 && !r_r) begin
        r_d <= 8'd1 << IR[ADDR_W +: 3];
        r_i <= IR[WIDTH-1];
      end
      if (r_sc == T2 && r_r) begin
        r_ien <= 1'b0;
        r_r   <= 1'b0;
      end else if (INT_EN != 0) begin
        if (w_ion) r_ien <= 1'b1;
        else if (w_iof) r_ien <= 1'b0;
        if (r_sc > T2 && r_ien && (FGI || FGO)) r_r <= 1'b1;
      end
    end
  end
  assign BUS_SEL = w_bus;
  assign ALU_OP  = w_alu;
  assign CTRL    = w_ctrl;
  assign HALTED  = !r_s;
  assign T_CNT   = r_sc;
endmodule

// File: tb/tb_bc_controller_v2.sv
// tb_bc_controller_v2: random instruction stream checked against a per-instruction trace model
module tb_bc_controller_v2;
  localparam logic [19:0] LD_AR = 20'h00001, INR_AR = 20'h00002, CLR_AR = 20'h00004, LD_PC = 20'h00008;
  localparam logic [19:0] INR_PC = 20'h00010, CLR_PC = 20'h00020, LD_DR = 20'h00040, INR_DR = 20'h00080;
  localparam logic [19:0] LD_AC = 20'h00100, INR_AC = 20'h00200, CLR_AC = 20'h00400, LD_IR = 20'h00800;
  localparam logic [19:0] LD_TR = 20'h01000, MEM_WR = 20'h02000, CMP_E = 20'h04000, CLR_E = 20'h08000;
  localparam logic [19:0] LD_E = 20'h10000, LD_OUTR = 20'h20000, CLR_FGI = 20'h40000, CLR_FGO = 20'h80000;
  logic clk = 0, rst = 1;
  logic [15:0] IR = '0;
  logic Z = 0, N = 0, E_IN = 0, DR_Z = 0, FGI = 0, FGO = 0, START = 0;
  logic [2:0] BUS_SEL, ALU_OP, T_CNT;
  logic [19:0] CTRL;
  logic HALTED;
  int n_chk = 0, n_err = 0, halt_len = 10;
  bit m_r = 0, m_ien = 0;
  typedef struct packed {
    logic [2:0]  bus;
    logic [2:0]  alu;
    logic [19:0] ctrl;
    logic [2:0]  t;
    logic        halted;
  } exp_t;
  exp_t tr[$];
  exp_t q[$];
  bc_controller_v2 dut (
    .clk(clk), .rst(rst), .IR(IR), .Z(Z), .N(N), .E_IN(E_IN), .DR_Z(DR_Z),
    .FGI(FGI), .FGO(FGO), .START(START), .BUS_SEL(BUS_SEL), .ALU_OP(ALU_OP),
    .CTRL(CTRL), .HALTED(HALTED), .T_CNT(T_CNT)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic add(input logic [2:0] b, input logic [2:0] a, input logic [19:0] c);
    exp_t e;
    e.bus = b; e.alu = a; e.ctrl = c; e.t = 3'(tr.size()); e.halted = 1'b0;
    tr.push_back(e);
  endtask
  // expected per-cycle trace of one whole instruction (or interrupt cycle)
  task automatic plan(input logic [15:0] ir, input logic [5:0] fl, output bit halt, output bit ion, output bit iof);
    int hb;
    logic z, n, e, drz, fgi, fgo;
    {z, n, e, drz, fgi, fgo} = fl;
    tr.delete();
    halt = 0; ion = 0; iof = 0;
    if (m_r) begin
      add(2, 0, CLR_AR | LD_TR); add(6, 0, MEM_WR | CLR_PC); add(0, 0, INR_PC);
    end else begin
      add(2, 0, LD_AR); add(7, 0, LD_IR | INR_PC); add(5, 0, LD_AR);
      if (ir[14:12] == 3'd7) begin
        hb = -1;
        for (int k = (ir[15] ? 6 : 0); k < 12; k++) if (ir[k]) hb = k;
        if (!ir[15]) begin
          case (hb)
            11: add(0, 0, CLR_AC);
            10: add(0, 0, CLR_E);
            9:  add(0, 3, LD_AC);
            8:  add(0, 0, CMP_E);
            7:  add(0, 4, LD_AC | LD_E);
            6:  add(0, 5, LD_AC | LD_E);
            5:  add(0, 0, INR_AC);
            4:  add(0, 0, !n ? INR_PC : 20'h0);
            3:  add(0, 0, n ? INR_PC : 20'h0);
            2:  add(0, 0, z ? INR_PC : 20'h0);
            1:  add(0, 0, !e ? INR_PC : 20'h0);
            0:  begin add(0, 0, 0); halt = 1; end
            default: add(0, 0, 0);
          endcase
        end else begin
          case (hb)
            11: add(0, 6, LD_AC | CLR_FGI);
            10: add(4, 0, LD_OUTR | CLR_FGO);
            9:  add(0, 0, fgi ? INR_PC : 20'h0);
            8:  add(0, 0, fgo ? INR_PC : 20'h0);
            7:  begin add(0, 0, 0); ion = 1; end
            6:  begin add(0, 0, 0); iof = 1; end
            default: add(0, 0, 0);
          endcase
        end
      end else begin
        add(ir[15] ? 3'd7 : 3'd0, 0, ir[15] ? LD_AR : 20'h0);
        case (ir[14:12])
          3'd0: begin add(7, 0, LD_DR); add(0, 1, LD_AC); end
          3'd1: begin add(7, 0, LD_DR); add(0, 0, LD_AC | LD_E); end
          3'd2: begin add(7, 0, LD_DR); add(0, 2, LD_AC); end
          3'd3: add(4, 0, MEM_WR);
          3'd4: add(1, 0, LD_PC);
          3'd5: begin add(2, 0, MEM_WR | INR_AR); add(1, 0, LD_PC); end
          default: begin add(7, 0, LD_DR); add(0, 0, INR_DR); add(3, 0, MEM_WR | (drz ? INR_PC : 20'h0)); end
        endcase
      end
    end
  endtask
  // drive one instruction from its T0 cycle, then advance the model's S/R/IEN
  task automatic run(input logic [15:0] ir, input logic [5:0] fl);
    bit h, on, off, was_r;
    exp_t hz;
    hz = '{bus: 3'd0, alu: 3'd0, ctrl: 20'h0, t: 3'd0, halted: 1'b1};
    IR = ir;
    {Z, N, E_IN, DR_Z, FGI, FGO} = fl;
    was_r = m_r;
    plan(ir, fl, h, on, off);
    foreach (tr[k]) q.push_back(tr[k]);
    repeat (tr.size()) @(posedge clk);
    #1;
    if (was_r) begin
      m_r = 0; m_ien = 0;
    end else begin
      if (m_ien && (fl[1] || fl[0])) m_r = 1;
      if (on) m_ien = 1;
      if (off) m_ien = 0;
      if (h) begin
        repeat (halt_len) begin q.push_back(hz); @(posedge clk); #1; end
        START = 1;
        q.push_back(hz);
        @(posedge clk); #1;
        START = 0;
      end
    end
  endtask
  // single compare process: one expected entry per clock cycle
  always @(negedge clk) begin : cmp
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("bus_sel", 32'(BUS_SEL), 32'(e.bus));
      chk("ctrl", 32'(CTRL), 32'(e.ctrl));
      chk("t_cnt", 32'(T_CNT), 32'(e.t));
      chk("halted", 32'(HALTED), 32'(e.halted));
      if ((e.ctrl & (LD_AC | LD_E)) != 0) chk("alu_op", 32'(ALU_OP), 32'(e.alu));
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [15:0] ir;
    logic [5:0] fl;
    int cls;
    bit h, on, off;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("reset_tcnt", 32'(T_CNT), 0);
    chk("reset_halted", 32'(HALTED), 0);
    chk("reset_bus", 32'(BUS_SEL), 2);
    run(16'h7020, 6'b0);
    chk("pin_inc_len", tr.size(), 4);
    chk("pin_inc_t3", 32'(tr[3].ctrl), 32'h00200);
    chk("inc_tcnt_back", 32'(T_CNT), 0);
    run(16'h1005, 6'b0);
    chk("pin_add_len", tr.size(), 6);
    chk("pin_add_t4", 32'(tr[4].ctrl), 32'h00040);
    chk("pin_add_t5", 32'(tr[5].ctrl), 32'h10100);
    run(16'h9005, 6'b0);
    chk("pin_ind_bus", 32'(tr[3].bus), 7);
    chk("pin_ind_ctrl", 32'(tr[3].ctrl), 32'h00001);
    run(16'h6010, 6'b000100);
    chk("pin_isz_len", tr.size(), 7);
    chk("pin_isz_t5", 32'(tr[5].ctrl), 32'h00080);
    chk("pin_isz_t6", 32'(tr[6].ctrl), 32'h02010);
    run(16'h6010, 6'b000000);
    chk("pin_isz_nz_t6", 32'(tr[6].ctrl), 32'h02000);
    run(16'h5020, 6'b0);
    chk("pin_bsa_t4", 32'(tr[4].ctrl), 32'h02002);
    chk("pin_bsa_t5_bus", 32'(tr[5].bus), 1);
    run(16'hF080, 6'b0);
    run(16'h7020, 6'b000010);
    run(16'h7020, 6'b0);
    chk("pin_int_len", tr.size(), 3);
    chk("pin_int_t0", 32'(tr[0].ctrl), 32'h01004);
    chk("pin_int_t2", 32'(tr[2].ctrl), 32'h00010);
    run(16'h7020, 6'b000010);
    run(16'h7020, 6'b0);
    chk("pin_ien_off_len", tr.size(), 4);
    halt_len = 10;
    run(16'h7001, 6'b0);
    chk("after_start_tcnt", 32'(T_CNT), 0);
    chk("after_start_halted", 32'(HALTED), 0);
    IR = 16'h1005;
    {Z, N, E_IN, DR_Z, FGI, FGO} = 6'b0;
    plan(16'h1005, 6'b0, h, on, off);
    foreach (tr[k]) q.push_back(tr[k]);
    repeat (4) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    q.delete();
    m_r = 0; m_ien = 0;
    chk("midrst_tcnt", 32'(T_CNT), 0);
    chk("midrst_halted", 32'(HALTED), 0);
    chk("midrst_bus", 32'(BUS_SEL), 2);
    for (int n = 0; n < 300; n++) begin
      cls = $urandom_range(0, 9);
      if (cls < 6) ir = {1'($urandom), 3'($urandom_range(0, 6)), 12'($urandom)};
      else if (cls < 8) ir = {4'h7, ($urandom_range(0, 1) != 0) ? 12'($urandom) : 12'(1) << $urandom_range(0, 11)};
      else ir = {4'hF, ($urandom_range(0, 1) != 0) ? 12'($urandom) : ((12'(1) << $urandom_range(6, 11)) | 12'($urandom_range(0, 63)))};
      fl = (6'($urandom) & 6'h3C) | {4'b0, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0)};
      halt_len = $urandom_range(1, 4);
      run(ir, fl);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
